// File: rtl/fp_seq_multiplier.sv
// Multi-cycle IEEE-754 single-precision multiplier, iterative shift-add.
// Define FP_MUL_ROUND_EN for round-to-nearest-even (one extra cycle).
module fp_seq_multiplier #(
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic        overflow,
   output logic        underflow
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_CHK  = 3'd1;
   localparam logic [2:0] S_MUL  = 3'd2;
   localparam logic [2:0] S_NORM = 3'd3;
`ifdef FP_MUL_ROUND_EN
   localparam logic [2:0] S_RND  = 3'd4;
`endif
   localparam logic [2:0] S_DONE = 3'd5;

   localparam logic [4:0] STEP = 5'(BITS_PER_CYCLE);
   localparam logic [4:0] LAST = 5'(24 - BITS_PER_CYCLE);

   logic [2:0]        state;
   logic [31:0]       a_r, b_r;
   logic [47:0]       acc, mshift, pp;
   logic [23:0]       mbr;
   logic [4:0]        cnt;
   logic signed [9:0] exp_r, exp_c, exp_n;
   logic              sign_r;

   logic [7:0]  ea, eb;
   logic [22:0] fa, fb, frac_t;
   logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
   logic        special;
   logic [31:0] spec_res;

   assign ea = a_r[30:23];
   assign eb = b_r[30:23];
   assign fa = a_r[22:0];
   assign fb = b_r[22:0];

   assign a_nan  = (ea == 8'hFF) && (fa != '0);
   assign b_nan  = (eb == 8'hFF) && (fb != '0);
   assign a_inf  = (ea == 8'hFF) && (fa == '0);
   assign b_inf  = (eb == 8'hFF) && (fb == '0);
   assign a_zero = (ea == 8'h00);
   assign b_zero = (eb == 8'h00);

   assign special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
   assign exp_c   = $signed({2'b0, ea} + {2'b0, eb} - 10'd127);

   always_comb begin
      spec_res = 32'h0000_0000;
      if (a_nan || b_nan)
         spec_res = 32'h7FC0_0000;
      else if ((a_zero && b_inf) || (a_inf && b_zero))
         spec_res = 32'h7FC0_0000;
      else if (a_inf || b_inf)
         spec_res = {a_r[31] ^ b_r[31], 8'hFF, 23'd0};
   end

   always_comb begin
      pp = '0;
      for (int i = 0; i < BITS_PER_CYCLE; i++)
         if (mbr[i]) pp = pp + (mshift << i);
   end

   assign frac_t = acc[47] ? acc[46:24] : acc[45:23];
   assign exp_n  = exp_r + (acc[47] ? 10'sd1 : 10'sd0);

   // {overflow, underflow, result} from a normalised exponent and fraction
   function automatic logic [33:0] pack(input logic s,
                                        input logic signed [9:0] e,
                                        input logic [22:0] f);
      if (e > 10'sd254)
         pack = {2'b10, s, 8'hFF, 23'd0};
      else if (e < 10'sd1)
         pack = {2'b01, 32'd0};
      else
         pack = {2'b00, s, e[7:0], f};
   endfunction

`ifdef FP_MUL_ROUND_EN
   logic              guard, sticky, rnd_up, rnd_r, carry;
   logic [22:0]       frac_r, frac_rnd;
   logic signed [9:0] exp_rnd;

   assign guard  = acc[47] ? acc[23] : acc[22];
   assign sticky = acc[47] ? |acc[22:0] : |acc[21:0];
   assign rnd_up = guard & (sticky | frac_t[0]);
   assign {carry, frac_rnd} = {1'b0, frac_r} + {23'd0, rnd_r};
   assign exp_rnd = exp_r + (carry ? 10'sd1 : 10'sd0);
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         a_r       <= '0;
         b_r       <= '0;
         acc       <= '0;
         mshift    <= '0;
         mbr       <= '0;
         cnt       <= '0;
         exp_r     <= '0;
         sign_r    <= 1'b0;
         result    <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
`ifdef FP_MUL_ROUND_EN
         frac_r    <= '0;
         rnd_r     <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  a_r   <= a;
                  b_r   <= b;
                  state <= S_CHK;
               end
            end
            S_CHK: begin
               sign_r <= a_r[31] ^ b_r[31];
               if (special) begin
                  {overflow, underflow, result} <= {2'b00, spec_res};
                  state <= S_DONE;
               end else begin
                  mshift <= {24'd0, 1'b1, fa};
                  mbr    <= {1'b1, fb};
                  acc    <= '0;
                  cnt    <= '0;
                  exp_r  <= exp_c;
                  state  <= S_MUL;
               end
            end
            S_MUL: begin
               acc    <= acc + pp;
               mshift <= mshift << STEP;
               mbr    <= mbr >> STEP;
               cnt    <= cnt + STEP;
               if (cnt == LAST) state <= S_NORM;
            end
            S_NORM: begin
`ifdef FP_MUL_ROUND_EN
               frac_r <= frac_t;
               exp_r  <= exp_n;
               rnd_r  <= rnd_up;
               state  <= S_RND;
`else
               {overflow, underflow, result} <= pack(sign_r, exp_n, frac_t);
               state <= S_DONE;
`endif
            end
`ifdef FP_MUL_ROUND_EN
            S_RND: begin
               {overflow, underflow, result} <= pack(sign_r, exp_rnd, frac_rnd);
               state <= S_DONE;
            end
`endif
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign busy = (state != S_IDLE) && (state != S_DONE);
   assign done = (state == S_DONE);

endmodule

// File: tb/tb_fp_seq_multiplier.sv
// Self-checking bench for fp_seq_multiplier: directed cases plus
// random operands against a plain-arithmetic reference model.
module tb_fp_seq_multiplier;

   localparam int BPC = 1;
`ifdef FP_MUL_ROUND_EN
   localparam int NORM_LAT = 4 + 24 / BPC;
`else
   localparam int NORM_LAT = 3 + 24 / BPC;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        busy, done, overflow, underflow;
   logic [31:0] result;

   int errors = 0;
   int checks = 0;

   fp_seq_multiplier #(.BITS_PER_CYCLE(BPC)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .result(result),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: {overflow, underflow, result} and accept-to-done latency
   task automatic model(input logic [31:0] x, input logic [31:0] y,
                        output logic [33:0] r, output int lat);
      logic [63:0] p;
      logic [22:0] f;
      int          e;
      logic        s, nx, ny, ix, iy, zx, zy;
      s  = x[31] ^ y[31];
      nx = (x[30:23] == 8'hFF) && (x[22:0] != 0);
      ny = (y[30:23] == 8'hFF) && (y[22:0] != 0);
      ix = (x[30:23] == 8'hFF) && (x[22:0] == 0);
      iy = (y[30:23] == 8'hFF) && (y[22:0] == 0);
      zx = (x[30:23] == 8'h00);
      zy = (y[30:23] == 8'h00);
      lat = 2;
      if (nx || ny) r = {2'b00, 32'h7FC00000};
      else if ((ix && zy) || (zx && iy)) r = {2'b00, 32'h7FC00000};
      else if (ix || iy) r = {2'b00, s, 8'hFF, 23'd0};
      else if (zx || zy) r = '0;
      else begin
         lat = NORM_LAT;
         p = {40'd0, 1'b1, x[22:0]} * {40'd0, 1'b1, y[22:0]};
         e = int'(x[30:23]) + int'(y[30:23]) - 127;
         if (p[47]) begin
            e++;
            f = p[46:24];
         end else
            f = p[45:23];
`ifdef FP_MUL_ROUND_EN
         begin
            logic g, st;
            logic [23:0] m;
            g  = p[47] ? p[23] : p[22];
            st = p[47] ? (p[22:0] != 0) : (p[21:0] != 0);
            m  = {1'b0, f};
            if (g && (st || f[0])) m = m + 24'd1;
            if (m[23]) e++;
            f = m[22:0];
         end
`endif
         if (e > 254) r = {2'b10, s, 8'hFF, 23'd0};
         else if (e < 1) r = {2'b01, 32'd0};
         else r = {2'b00, s, 8'(e), f};
      end
   endtask

   // inj: latency count at which a stray start with junk operands is driven
   task automatic run_op(input string tag, input logic [31:0] ta,
                         input logic [31:0] tb_v, input int inj);
      logic [33:0] ev;
      int want, lat, ndone;
      model(ta, tb_v, ev, want);
      @(negedge clk);
      a = ta;
      b = tb_v;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      a = $urandom;
      b = $urandom;
      lat = 1;
      check({tag, "_busy"}, {63'd0, busy}, 64'd1);
      while (!done && lat < 80) begin
         if (lat == inj) begin
            start = 1'b1;
            a = $urandom;
            b = $urandom;
         end
         @(posedge clk);
         #1;
         start = 1'b0;
         lat++;
      end
      check({tag, "_done"}, {63'd0, done}, 64'd1);
      check({tag, "_lat"}, 64'(lat), 64'(want));
      check({tag, "_res"}, {30'd0, overflow, underflow, result}, {30'd0, ev});
      ndone = 0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (done || busy) ndone++;
      end
      check({tag, "_idle"}, 64'(ndone), 64'd0);
      check({tag, "_hold"}, {30'd0, overflow, underflow, result}, {30'd0, ev});
   endtask

   function automatic logic [31:0] rand_fp();
      logic [31:0] sp [7];
      sp = '{32'h7FC00000, 32'h7F800000, 32'hFF800000, 32'h00000000,
             32'h80000000, 32'h00000123, 32'h7F800001};
      if ($urandom_range(0, 5) == 0)
         return sp[$urandom_range(0, 6)];
      return {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
   endfunction

   initial begin
      #12;
      check("reset_out", {29'd0, busy, done, overflow, underflow, result}, 64'd0);
      @(negedge clk);
      reset_n = 1'b1;

      run_op("t1_1p5x2", 32'h3FC00000, 32'h40000000, 0);
      run_op("t2_nan", 32'h7FC00000, 32'h3F800000, 0);
      run_op("t2_0xinf", 32'h00000000, 32'hFF800000, 0);
      run_op("t2_inf", 32'hBF800000, 32'h7F800000, 0);
      run_op("t2_zero", 32'h80000000, 32'h40000000, 0);
      run_op("t3_ovf", 32'h7F000000, 32'h7F000000, 0);
      run_op("t3_unf", 32'h00800000, 32'h00800000, 0);
      run_op("t4_round", 32'h3FC00001, 32'h3FC00000, 0);
      run_op("t5_ignore", 32'h40490FDB, 32'hC0000000, 6);

      // Abort mid-multiply with a prior nonzero result on the outputs
      @(negedge clk);
      a = 32'h40400000;
      b = 32'h40400000;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("t6_reset", {29'd0, busy, done, overflow, underflow, result}, 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      run_op("t6_after", 32'h40400000, 32'h40400000, 0);

      for (int i = 0; i < 24; i++)
         run_op($sformatf("rnd%0d", i), rand_fp(), rand_fp(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
